// File: rtl/systolic_matmul_nxn.sv
// -----------------------------------------------------------------------------
// systolic_matmul_nxn
//   Computes C = A x B on an NxN output-stationary grid of processing
//   elements (PEs). A columns flow rightwards and B rows flow downwards. Each
//   PE accumulates its C[i][j] in place. Operand skew is applied internally.
//   The finished matrix is then streamed out one row per handshake.
//
// Parameters
//   DATA_W  operand element width
//   N       array dimension (2..16)
//   ACC_W   accumulator / result element width (wraps, never saturates)
//   SIGNED  0: unsigned operands, 1: two's-complement operands
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     operand beat handshake
//   a_col                   lane i = A[i][k]
//   b_row                   lane j = B[k][j]
//   out_valid / out_ready   result row handshake
//   out_row                 lane j = C[r][j]
//   out_row_idx             row index r
//   busy                    high whenever the block is not idle
// -----------------------------------------------------------------------------
module systolic_matmul_nxn #(
  parameter int DATA_W = 8,
  parameter int N      = 4,
  parameter int ACC_W  = 2*DATA_W + $clog2(N),
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DATA_W-1:0]  a_col,
  input  logic [N*DATA_W-1:0]  b_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*ACC_W-1:0]   out_row,
  output logic [$clog2(N)-1:0] out_row_idx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(2*N);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(N-1);
  // The last product reaches PE(N-1,N-1) 2N-2 edges after the final beat.
  // One more edge moves the block into OUTPUT.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*N-2);
  localparam logic [IDX_W-1:0] ROW_LAST   = IDX_W'(N-1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] row_idx;
  logic             accept;
  logic             acc_clr;

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign acc_clr   = (state == OUTPUT) && out_ready && (row_idx == ROW_LAST);

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      row_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= LOAD;
            cnt   <= CNT_W'(1);
          end
        end
        LOAD: begin
          if (accept) begin
            if (cnt == LAST_BEAT) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= OUTPUT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (row_idx == ROW_LAST) begin
              state   <= IDLE;
              row_idx <= '0;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- injection + skew
  // Cycles without an accepted beat inject zeros, so bubbles add nothing.
  logic [DATA_W-1:0] a_inj  [N];
  logic [DATA_W-1:0] b_inj  [N];
  logic [DATA_W-1:0] a_edge [N];
  logic [DATA_W-1:0] b_edge [N];

  always_comb begin
    for (int unsigned l = 0; l < N; l++) begin
      a_inj[l] = accept ? a_col[l*DATA_W +: DATA_W] : '0;
      b_inj[l] = accept ? b_row[l*DATA_W +: DATA_W] : '0;
    end
  end

  for (genvar l = 0; l < N; l++) begin : g_skew
    if (l == 0) begin : g_direct
      assign a_edge[l] = a_inj[l];
      assign b_edge[l] = b_inj[l];
    end else begin : g_delay
      logic [DATA_W-1:0] a_sr [l];
      logic [DATA_W-1:0] b_sr [l];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned s = 0; s < l; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_inj[l];
          b_sr[0] <= b_inj[l];
          for (int unsigned s = 1; s < l; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_edge[l] = a_sr[l-1];
      assign b_edge[l] = b_sr[l-1];
    end
  end

  // ------------------------------------------------------------- PE grid
  // a_pipe[i][j] is the A value leaving PE(i,j) to the right. b_pipe[i][j]
  // is the B value leaving PE(i,j) downwards. The outermost PEs need no
  // forwarding register.
  logic [DATA_W-1:0] a_pipe [N][N-1];
  logic [DATA_W-1:0] b_pipe [N-1][N];
  logic [ACC_W-1:0]  acc    [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0]   a_in;
      logic [DATA_W-1:0]   b_in;
      logic [2*DATA_W-1:0] a_ext;
      logic [2*DATA_W-1:0] b_ext;
      logic [2*DATA_W-1:0] prod;
      logic [ACC_W-1:0]    prod_ext;
      logic [ACC_W-1:0]    acc_q;

      if (j == 0) begin : g_a_edge
        assign a_in = a_edge[i];
      end else begin : g_a_pass
        assign a_in = a_pipe[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_edge[j];
      end else begin : g_b_pass
        assign b_in = b_pipe[i-1][j];
      end

      // Both operands are extended to 2*DATA_W first. The low 2*DATA_W
      // product bits are then correct for either signedness.
      always_comb begin
        a_ext    = {{DATA_W{(SIGNED != 0) && a_in[DATA_W-1]}}, a_in};
        b_ext    = {{DATA_W{(SIGNED != 0) && b_in[DATA_W-1]}}, b_in};
        prod     = a_ext * b_ext;
        prod_ext = '0;
        prod_ext[2*DATA_W-1:0] = prod;
        for (int unsigned t = 2*DATA_W; t < ACC_W; t++) begin
          prod_ext[t] = (SIGNED != 0) && prod[2*DATA_W-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset || acc_clr) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_q + prod_ext;
        end
      end
      assign acc[i][j] = acc_q;

      if (j < N-1) begin : g_a_fwd
        logic [DATA_W-1:0] a_q;
        always_ff @(posedge clk) begin
          if (reset) a_q <= '0;
          else       a_q <= a_in;
        end
        assign a_pipe[i][j] = a_q;
      end
      if (i < N-1) begin : g_b_fwd
        logic [DATA_W-1:0] b_q;
        always_ff @(posedge clk) begin
          if (reset) b_q <= '0;
          else       b_q <= b_in;
        end
        assign b_pipe[i][j] = b_q;
      end
    end
  end

  // ------------------------------------------------------------- output
  always_comb begin
    out_row = '0;
    if (state == OUTPUT) begin
      for (int unsigned c = 0; c < N; c++) begin
        out_row[c*ACC_W +: ACC_W] = acc[row_idx][c];
      end
    end
  end

  assign out_row_idx = (state == OUTPUT) ? row_idx : '0;

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
module tb_systolic_matmul_nxn;

  localparam int DW  = 8;
  localparam int N1  = 4;
  localparam int AW1 = 18;
  localparam int N2  = 2;
  localparam int AW2 = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic              in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [N1*DW-1:0]  a_col1, b_row1;
  logic [N1*AW1-1:0] out_row1;
  logic [1:0]        out_idx1;

  logic              in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [N2*DW-1:0]  a_col2, b_row2;
  logic [N2*AW2-1:0] out_row2;
  logic [0:0]        out_idx2;

  systolic_matmul_nxn #(.DATA_W(DW), .N(N1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_col(a_col1), .b_row(b_row1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_row(out_row1), .out_row_idx(out_idx1), .busy(busy1));

  systolic_matmul_nxn #(.DATA_W(DW), .N(N2), .SIGNED(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_col(a_col2), .b_row(b_row2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_row(out_row2), .out_row_idx(out_idx2), .busy(busy2));

  int vectors    = 0;
  int miscompares = 0;

  typedef struct { logic [N1*AW1-1:0] row; logic [1:0] idx; } exp1_t;
  typedef struct { logic [N2*AW2-1:0] row; logic [0:0] idx; } exp2_t;
  exp1_t q1[$];
  exp2_t q2[$];

  int ma [N1][N1];
  int mb [N1][N1];
  int sa [N2][N2];
  int sb [N2][N2];
  logic [N1*AW1-1:0] exp_rows1 [N1];

  // ------------------------------------------------------------ reference
  task automatic push1();
    exp1_t e;
    int c;
    for (int r = 0; r < N1; r++) begin
      e.row = '0;
      e.idx = 2'(r);
      for (int j = 0; j < N1; j++) begin
        c = 0;
        for (int k = 0; k < N1; k++) c += ma[r][k] * mb[k][j];
        e.row[j*AW1 +: AW1] = AW1'(c);
      end
      exp_rows1[r] = e.row;
      q1.push_back(e);
    end
  endtask

  task automatic push2();
    exp2_t e;
    int c;
    for (int r = 0; r < N2; r++) begin
      e.row = '0;
      e.idx = 1'(r);
      for (int j = 0; j < N2; j++) begin
        c = 0;
        for (int k = 0; k < N2; k++) c += sa[r][k] * sb[k][j];
        e.row[j*AW2 +: AW2] = AW2'(c);
      end
      q2.push_back(e);
    end
  endtask

  task automatic rand1();
    for (int i = 0; i < N1; i++)
      for (int k = 0; k < N1; k++) begin
        ma[i][k] = int'($urandom_range(255));
        mb[i][k] = int'($urandom_range(255));
      end
  endtask

  task automatic ident1();
    for (int i = 0; i < N1; i++)
      for (int k = 0; k < N1; k++) begin
        ma[i][k] = (i == k) ? 1 : 0;
        mb[i][k] = 4*i + k + 1;
      end
  endtask

  // ------------------------------------------------------------ drivers
  task automatic feed1(input int gap, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      for (int i = 0; i < N1; i++) begin
        a_col1[i*DW +: DW] = DW'(ma[i][k]);
        b_row1[i*DW +: DW] = DW'(mb[k][i]);
      end
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic feed2(input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      for (int i = 0; i < N2; i++) begin
        a_col2[i*DW +: DW] = DW'(sa[i][k]);
        b_row2[i*DW +: DW] = DW'(sb[k][i]);
      end
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
    end
  endtask

  task automatic drain1(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (q1.size() == 0 && busy1 === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drain2(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (q2.size() == 0 && busy2 === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  // ------------------------------------------------------------ scoreboards
  always @(negedge clk) begin
    if (out_valid1 === 1'b1) begin
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("FAIL dut1_row_unexpected: got idx=%0d row=%h, expected no row", out_idx1, out_row1);
      end else begin
        if (out_row1 !== q1[0].row || out_idx1 !== q1[0].idx) begin
          miscompares++;
          $display("FAIL dut1_row: got idx=%0d row=%h, expected idx=%0d row=%h",
                   out_idx1, out_row1, q1[0].idx, q1[0].row);
        end
        if (out_ready1 === 1'b1) void'(q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid2 === 1'b1) begin
      vectors++;
      if (q2.size() == 0) begin
        miscompares++;
        $display("FAIL dut2_row_unexpected: got idx=%0d row=%h, expected no row", out_idx2, out_row2);
      end else begin
        if (out_row2 !== q2[0].row || out_idx2 !== q2[0].idx) begin
          miscompares++;
          $display("FAIL dut2_row: got idx=%0d row=%h, expected idx=%0d row=%h",
                   out_idx2, out_row2, q2[0].idx, q2[0].row);
        end
        if (out_ready2 === 1'b1) void'(q2.pop_front());
      end
    end
  end

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    reset = 1'b1;
    in_valid1 = 1'b1; a_col1 = '1; b_row1 = '1; out_ready1 = 1'b1;
    in_valid2 = 1'b1; a_col2 = '1; b_row2 = '1; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    vectors++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || busy1 !== 1'b0 ||
        out_row1 !== '0 || out_idx1 !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_dut1: got rdy=%b vld=%b busy=%b row=%h idx=%0d, expected 1 0 0 0 0",
               in_ready1, out_valid1, busy1, out_row1, out_idx1);
    end
    vectors++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || busy2 !== 1'b0 ||
        out_row2 !== '0 || out_idx2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dut2: got rdy=%b vld=%b busy=%b row=%h idx=%0d, expected 1 0 0 0 0",
               in_ready2, out_valid2, busy2, out_row2, out_idx2);
    end
  endtask

  task automatic test_identity();
    int first;
    int run;
    ident1();
    push1();
    out_ready1 = 1'b1;
    feed1(0, N1);
    first = 0;
    // Junk offered while draining must be ignored.
    for (int e = 1; e <= 20; e++) begin
      in_valid1 = 1'b1;
      a_col1 = $urandom;
      b_row1 = $urandom;
      @(posedge clk); #1;
      if (e == 1) begin
        vectors++;
        if (in_ready1 !== 1'b0 || busy1 !== 1'b1) begin
          miscompares++;
          $display("FAIL drain_flags: got in_ready=%b busy=%b, expected 0 1", in_ready1, busy1);
        end
      end
      if (out_valid1 === 1'b1) begin first = e; break; end
    end
    in_valid1 = 1'b0;
    vectors++;
    if (first != 7) begin
      miscompares++;
      $display("FAIL out_latency: got %0d edges, expected 7", first);
    end
    run = 1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (out_valid1 === 1'b1) run++;
      else break;
    end
    vectors++;
    if (run != 4) begin
      miscompares++;
      $display("FAIL out_valid_run: got %0d cycles, expected 4", run);
    end
    vectors++;
    if (q1.size() != 0) begin
      miscompares++;
      $display("FAIL identity_rows_left: got %0d pending, expected 0", q1.size());
    end
  endtask

  task automatic test_max();
    bit ok;
    for (int i = 0; i < N1; i++)
      for (int k = 0; k < N1; k++) begin ma[i][k] = 255; mb[i][k] = 255; end
    push1();
    feed1(0, N1);
    drain1(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL max_drain: got pending=%0d busy=%b, expected 0 0", q1.size(), busy1);
    end
  endtask

  task automatic test_bubbles();
    int drops;
    bit ok;
    ident1();
    push1();
    drops = 0;
    for (int k = 0; k < N1; k++) begin
      for (int i = 0; i < N1; i++) begin
        a_col1[i*DW +: DW] = DW'(ma[i][k]);
        b_row1[i*DW +: DW] = DW'(mb[k][i]);
      end
      if (in_ready1 !== 1'b1) drops++;
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      a_col1 = $urandom;
      b_row1 = $urandom;
      if (k < N1-1) begin
        repeat (2) begin
          if (in_ready1 !== 1'b1) drops++;
          @(posedge clk); #1;
        end
      end
    end
    vectors++;
    if (drops != 0) begin
      miscompares++;
      $display("FAIL bubble_in_ready: got %0d low cycles, expected 0", drops);
    end
    drain1(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bubble_drain: got pending=%0d busy=%b, expected 0 0", q1.size(), busy1);
    end
  endtask

  task automatic test_backpressure();
    bit found;
    bit ok;
    rand1();
    push1();
    out_ready1 = 1'b1;
    feed1(1, N1);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (out_valid1 === 1'b1 && out_idx1 === 2'd1) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL stall_row1_seen: got none, expected row 1 within 40 cycles");
    end
    out_ready1 = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid1 !== 1'b1 || out_idx1 !== 2'd1 || out_row1 !== exp_rows1[1]) begin
        miscompares++;
        $display("FAIL stall_hold: got vld=%b idx=%0d row=%h, expected 1 1 %h",
                 out_valid1, out_idx1, out_row1, exp_rows1[1]);
      end
    end
    out_ready1 = 1'b1;
    drain1(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL stall_drain: got pending=%0d busy=%b, expected 0 0", q1.size(), busy1);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    rand1();
    feed1(0, N1-1);
    reset = 1'b1;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid1 = 1'b0;
    vectors++;
    if (busy1 !== 1'b0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_flags: got busy=%b rdy=%b vld=%b, expected 0 1 0", busy1, in_ready1, out_valid1);
    end
    repeat (12) begin @(posedge clk); #1; end
    rand1();
    push1();
    feed1(0, N1);
    drain1(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL abort_new_drain: got pending=%0d busy=%b, expected 0 0", q1.size(), busy1);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    bit ok;
    rand1();
    push1();
    feed1(0, N1);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (out_valid1 === 1'b1 && out_idx1 === 2'd3) begin found = 1'b1; break; end
    end
    @(posedge clk); #1;
    vectors++;
    if (!found || busy1 !== 1'b0 || in_ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle: got found=%b busy=%b rdy=%b, expected 1 0 1", found, busy1, in_ready1);
    end
    rand1();
    push1();
    feed1(0, N1);
    drain1(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_drain: got pending=%0d busy=%b, expected 0 0", q1.size(), busy1);
    end
  endtask

  task automatic test_signed();
    bit found;
    bit ok;
    for (int i = 0; i < N2; i++)
      for (int k = 0; k < N2; k++) begin sa[i][k] = -1; sb[i][k] = -1; end
    push2();
    out_ready2 = 1'b1;
    feed2(N2);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (out_valid2 === 1'b1 && out_idx2 === 1'b1) begin found = 1'b1; break; end
    end
    @(posedge clk); #1;
    vectors++;
    if (!found || busy2 !== 1'b0 || in_ready2 !== 1'b1) begin
      miscompares++;
      $display("FAIL signed_idle: got found=%b busy=%b rdy=%b, expected 1 0 1", found, busy2, in_ready2);
    end
    for (int i = 0; i < N2; i++)
      for (int k = 0; k < N2; k++) begin
        sa[i][k] = int'($urandom_range(255)) - 128;
        sb[i][k] = int'($urandom_range(255)) - 128;
      end
    push2();
    feed2(N2);
    drain2(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL signed_drain: got pending=%0d busy=%b, expected 0 0", q2.size(), busy2);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid1 = 1'b0; a_col1 = '0; b_row1 = '0; out_ready1 = 1'b1;
    in_valid2 = 1'b0; a_col2 = '0; b_row2 = '0; out_ready2 = 1'b1;
    test_reset();
    test_identity();
    test_max();
    test_bubbles();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_signed();
    repeat (3) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got no completion by 200000, expected finish earlier");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
